// File: rtl/instr_fetch_pkg.sv
// Shared fetch-path definitions, also used by the Pc register and decode.
// Holds the default word/address widths, the reset vector and the fetch
// controller state encoding.
package instr_fetch_pkg;

    localparam int DefaultAddrWidth  = 16;
    localparam int DefaultDataWidth  = 16;
    localparam int DefaultQueueDepth = 2;

    localparam logic [DefaultAddrWidth-1:0] DefaultResetVector = 16'h0000;

    typedef enum logic [1:0] {
        StBoot  = 2'd0,
        StReq   = 2'd1,
        StIdle  = 2'd2,
        StDrain = 2'd3
    } fetchState_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of {instruction, pc} pairs between memory and decode.
// Ports:
//   Clk, Rst              clock, asynchronous active-high reset
//   Push, PushInstr/Pc    write one entry (ignored when full with no pop)
//   Pop                   remove head (ignored when empty)
//   Clear                 empty the queue; wins over push and pop
//   Count                 current occupancy 0..Depth
//   HeadInstr, HeadPc     head entry, meaningful only when Count != 0
module fetch_queue #(
    parameter int DataWidth = 16,
    parameter int AddrWidth = 16,
    parameter int Depth     = 2,
    localparam int CountWidth = $clog2(Depth) + 1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  Push,
    input  logic [DataWidth-1:0]  PushInstr,
    input  logic [AddrWidth-1:0]  PushPc,
    input  logic                  Pop,
    input  logic                  Clear,
    output logic [CountWidth-1:0] Count,
    output logic [DataWidth-1:0]  HeadInstr,
    output logic [AddrWidth-1:0]  HeadPc
);

    localparam int PtrWidth = $clog2(Depth);
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(Depth);

    logic [DataWidth+AddrWidth-1:0] entries [Depth];
    logic [PtrWidth-1:0] rdPtr;
    logic [PtrWidth-1:0] wrPtr;
    logic doPush;
    logic doPop;

    assign doPop  = Pop && (Count != '0);
    assign doPush = Push && ((Count != FullCount) || doPop);

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            rdPtr <= '0;
            wrPtr <= '0;
            Count <= '0;
        end else if (Clear) begin
            rdPtr <= '0;
            wrPtr <= '0;
            Count <= '0;
        end else begin
            // Depth is a power of two, so the pointers wrap on their own.
            if (doPush) wrPtr <= wrPtr + PtrWidth'(1);
            if (doPop)  rdPtr <= rdPtr + PtrWidth'(1);
            Count <= Count + CountWidth'(doPush) - CountWidth'(doPop);
        end
    end

    always_ff @(posedge Clk) begin
        if (doPush && !Clear) entries[wrPtr] <= {PushInstr, PushPc};
    end

    assign {HeadInstr, HeadPc} = entries[rdPtr];

endmodule

// File: rtl/instr_fetch.sv
// Fetch controller between the Pc register and decode. Owns the next-PC mux,
// reads instruction words over a req/ack handshake, queues them and hands them
// to decode over valid/ready. A redirect flushes the queue and restarts at the
// target, first draining any fetch that is still outstanding.
// Ports:
//   Clk, Rst                 clock, asynchronous active-high reset
//   PcOutput / PcInput       current PC in, next PC out (Pc captures every edge)
//   MemReq, MemAddr          fetch request and word address
//   MemAck, MemData          read completion and instruction word
//   InstrValid, InstrReady   decode handshake for the queue head
//   Instr, InstrPc           head instruction word and its address
//   Redirect, RedirectPc     taken branch/jump and its target
//
// state | meaning
// BOOT  | one cycle forcing PcInput to the reset vector
// REQ   | requesting the word at PcOutput; advances PC on ack
// IDLE  | queue full, no request, PC held
// DRAIN | waiting out a fetch orphaned by a redirect; data discarded
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int AddrWidth  = DefaultAddrWidth,
    parameter int DataWidth  = DefaultDataWidth,
    parameter int QueueDepth = DefaultQueueDepth,
    parameter logic [AddrWidth-1:0] ResetVector = AddrWidth'(DefaultResetVector)
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [AddrWidth-1:0] PcOutput,
    output logic [AddrWidth-1:0] PcInput,
    output logic                 MemReq,
    output logic [AddrWidth-1:0] MemAddr,
    input  logic                 MemAck,
    input  logic [DataWidth-1:0] MemData,
    output logic                 InstrValid,
    input  logic                 InstrReady,
    output logic [DataWidth-1:0] Instr,
    output logic [AddrWidth-1:0] InstrPc,
    input  logic                 Redirect,
    input  logic [AddrWidth-1:0] RedirectPc
);

    localparam int CountWidth = $clog2(QueueDepth) + 1;
    localparam logic [CountWidth-1:0] FullCount = CountWidth'(QueueDepth);

    fetchState_t state;
    logic [AddrWidth-1:0] reqAddr;
    logic [CountWidth-1:0] count;
    logic [CountWidth-1:0] occAfter;
    logic push;
    logic pop;

    always_comb begin
        MemReq     = (state == StReq) || (state == StDrain);
        MemAddr    = (state == StDrain) ? reqAddr : PcOutput;
        // Decode never sees the head during a redirect, so nothing is popped
        // from a queue that is being flushed anyway.
        InstrValid = (count != '0) && !Redirect;
        pop        = InstrValid && InstrReady;
        push       = (state == StReq) && MemAck && !Redirect;
        occAfter   = count + CountWidth'(push) - CountWidth'(pop);

        if (Redirect) begin
            PcInput = RedirectPc;
        end else begin
            case (state)
                StBoot:  PcInput = ResetVector;
                StReq:   PcInput = MemAck ? PcOutput + AddrWidth'(1) : PcOutput;
                default: PcInput = PcOutput;
            endcase
        end
    end

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state   <= StBoot;
            reqAddr <= ResetVector;
        end else begin
            case (state)
                StBoot: state <= StReq;
                StReq: begin
                    // Remembered so DRAIN can keep presenting the orphaned
                    // address after PcOutput has moved to the redirect target.
                    reqAddr <= PcOutput;
                    if (Redirect)
                        state <= MemAck ? StReq : StDrain;
                    else if (MemAck && (occAfter >= FullCount))
                        state <= StIdle;
                end
                StIdle: begin
                    if (Redirect || (occAfter < FullCount)) state <= StReq;
                end
                StDrain: begin
                    if (MemAck) state <= StReq;
                end
                default: state <= StBoot;
            endcase
        end
    end

    fetch_queue #(
        .DataWidth(DataWidth),
        .AddrWidth(AddrWidth),
        .Depth    (QueueDepth)
    ) u_queue (
        .Clk      (Clk),
        .Rst      (Rst),
        .Push     (push),
        .PushInstr(MemData),
        .PushPc   (PcOutput),
        .Pop      (pop),
        .Clear    (Redirect),
        .Count    (count),
        .HeadInstr(Instr),
        .HeadPc   (InstrPc)
    );

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Fetch controller between the `Pc` register and the decode stage. Consumes `PcOutput` and drives `PcInput`, so it alone decides when the PC advances, holds, or jumps. Reads 16-bit instruction words from instruction memory over a req/ack handshake and buffers them in a small queue. Hands them to decode over a valid/ready interface, and flushes on branch redirect.

## Interface
- `AddrWidth`, 16: PC / memory address width (word-addressed).
- `DataWidth`, 16: instruction word width.
- `QueueDepth`, 2: instruction queue entries (power of two, ≥2).
- `ResetVector`, 16'h0000: PC value forced after reset.
- `Clk` in 1: the single clock, rising edge.
- `Rst` in 1: asynchronous, active-high reset.
- `PcOutput` in AddrWidth: current PC from `Pc`.
- `PcInput` out AddrWidth: next PC to `Pc`, captured by `Pc` every `Clk` edge.
- `MemReq` out 1: fetch request.
- `MemAddr` out AddrWidth: fetch word address.
- `MemAck` in 1: the read completes at this edge when `MemReq`=1.
- `MemData` in DataWidth: instruction word, valid with `MemAck`.
- `InstrValid` out 1: queue head valid.
- `InstrReady` in 1: decode accepts the head.
- `Instr` out DataWidth: head instruction word.
- `InstrPc` out AddrWidth: address of the head instruction.
- `Redirect` in 1: branch/jump taken; flush and restart.
- `RedirectPc` in AddrWidth: redirect target.

## Operation
- FSM states: BOOT, REQ, IDLE, DRAIN. Reset state is BOOT.
- Reset values: queue empty, `InstrValid`=0, `MemReq`=0, `PcInput`=`ResetVector`.
- BOOT: drive `PcInput`=`ResetVector` for one cycle, then go to REQ.
- REQ: `MemReq`=1 and `MemAddr`=`PcOutput`.
  - No ack: hold `PcInput`=`PcOutput`.
  - On `MemAck`: push {`MemData`, `PcOutput`} and drive `PcInput`=`PcOutput`+1.
  - After the ack, stay in REQ if occupancy after push/pop < `QueueDepth`; otherwise go to IDLE.
- IDLE: `MemReq`=0 and `PcInput`=`PcOutput`. Go to REQ when occupancy after this cycle's pop < `QueueDepth`.
- Pop: `InstrValid`&&`InstrReady` removes the head. `Instr`/`InstrPc` always show the head entry.
- PC increment wraps modulo 2^AddrWidth: 16'hFFFF → 16'h0000.
- Redirect, which has priority over everything except `Rst`:
  - `PcInput`=`RedirectPc` and the queue is cleared at the edge.
  - `InstrValid` is forced to 0 during the `Redirect` cycle, so no pop happens.
  - From REQ without `MemAck`: go to DRAIN. `ReqAddr` holds the outstanding address.
  - From REQ with `MemAck`: discard the data and go to REQ.
  - From IDLE or BOOT: go to REQ.
- DRAIN: `MemReq`=1 and `MemAddr`=`ReqAddr` (stable until acked); `PcInput`=`PcOutput`.
  - On `MemAck`: discard the data and go to REQ.
  - A further `Redirect` in DRAIN updates `PcInput`=`RedirectPc` and stays in DRAIN.
- `ReqAddr` tracks `PcOutput` every cycle in REQ.
- `Rst` mid-fetch: immediate return to BOOT. Any outstanding memory ack after reset is ignored, because BOOT does not sample `MemAck`.

## Timing
- `PcInput`, `MemReq`, `MemAddr` and `InstrValid` are combinational from state, queue and inputs.
- Queue and FSM update on the rising `Clk` edge.
- Zero-wait memory (ack in the request cycle): one instruction per cycle sustained.
- Instruction enters the queue at the ack edge and is visible on `Instr` the next cycle.
- `MemReq`/`MemAddr` are stable from assertion until the ack edge.
- Redirect to first request on target: next cycle if no fetch is outstanding; otherwise the cycle after the drained ack.

## Structure
- Shared definitions header, also used by `Pc` and decode: FSM state encodings, `ResetVector`, word/address width constants.
- Sub-module `fetch_queue`: parameterised synchronous FIFO with push/pop/clear, count, and head data {instr, pc}.
- The FSM and PC mux stay in `instr_fetch`.

## Test plan
- Reset release with zero-wait memory and `InstrReady`=1. Required: `PcInput`=0000 in BOOT, then `MemAddr` 0000, 0001, 0002 on consecutive cycles, and `InstrPc` 0000, 0001, … one cycle later.
- Stall: `InstrReady`=0. Required: exactly 2 pushes, then IDLE with `MemReq`=0 and PC held. After `InstrReady`=1, requests resume only once a slot frees.
- Wait states: `MemAck` delayed 3 cycles. Required: `MemAddr` stable throughout and `PcInput`=`PcOutput` until the ack cycle.
- Redirect to 0x0040 while a fetch of 0x0005 is unacked. Required: DRAIN keeps `MemAddr`=0005; after the ack the data is discarded, and the next `MemAddr`=0040 with `InstrPc`=0040.
- Start at 0xFFFE via redirect. Required: fetches FFFE, FFFF, 0000.
- Assert `Rst` mid-DRAIN. Required: queue empty, `InstrValid`=0, `PcInput`=`ResetVector`, and a late ack is ignored.
